// File: rtl/mem_read_a_if.sv
// Control/size inputs and banked read outputs of the A-matrix read-address generator.
// The generator itself is the slave; whoever drives start/sizes/stall is the master.
interface mem_read_a_if #(
  parameter int N1           = 4,
  parameter int MATRIXSIZE_W = 16,
  parameter int ADDR_W       = 12
);
  logic                    start;
  logic [MATRIXSIZE_W-1:0] M2;
  logic [MATRIXSIZE_W-1:0] M1dN1;
  logic [MATRIXSIZE_W-1:0] M3dN2;
  logic                    stall;
  logic [N1*ADDR_W-1:0]    rd_addr_A;
  logic [N1-1:0]           rd_en_A;
  logic [N1-1:0]           rd_last_A;
  logic                    busy;
  logic                    done;

  modport master (
    output start, M2, M1dN1, M3dN2, stall,
    input  rd_addr_A, rd_en_A, rd_last_A, busy, done
  );

  modport slave (
    input  start, M2, M1dN1, M3dN2, stall,
    output rd_addr_A, rd_en_A, rd_last_A, busy, done
  );
endinterface

// File: rtl/mem_read_a.sv
// Read-address generator for the N1 banked A buffers: replays each row-block once per
// B column-block and skews bank k by k cycles to feed the west edge of the systolic array.
module mem_read_a #(
  parameter int N1           = 4,
  parameter int MATRIXSIZE_W = 16,
  parameter int ADDR_W       = 12
) (
  input  logic        clk,
  input  logic        rst,
  mem_read_a_if.slave bus
);

  localparam int DRAIN_W = (N1 > 1) ? $clog2(N1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [MATRIXSIZE_W-1:0] m2_q, m2_d;
  logic [MATRIXSIZE_W-1:0] m1_q, m1_d;
  logic [MATRIXSIZE_W-1:0] m3_q, m3_d;
  logic [MATRIXSIZE_W-1:0] j_q, j_d;
  logic [MATRIXSIZE_W-1:0] c_q, c_d;
  logic [MATRIXSIZE_W-1:0] r_q, r_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [DRAIN_W-1:0]      drain_q, drain_d;

  logic [ADDR_W-1:0]       lane_addr_q [N1];
  logic [ADDR_W-1:0]       lane_addr_d [N1];
  logic [N1-1:0]           lane_en_q, lane_en_d;
  logic [N1-1:0]           lane_last_q, lane_last_d;

  // In IDLE the sizes are not latched yet, so the first issue uses the live inputs.
  logic [MATRIXSIZE_W-1:0] sz_m2, sz_m1, sz_m3;
  logic [MATRIXSIZE_W-1:0] m2_max, m1_max, m3_max;
  logic                    issue;
  logic                    j_wrap, c_wrap, final_issue;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    m2_d        = m2_q;
    m1_d        = m1_q;
    m3_d        = m3_q;
    j_d         = j_q;
    c_d         = c_q;
    r_d         = r_q;
    base_d      = base_q;
    drain_d     = drain_q;
    issue       = 1'b0;

    sz_m2       = (state_q == IDLE) ? bus.M2    : m2_q;
    sz_m1       = (state_q == IDLE) ? bus.M1dN1 : m1_q;
    sz_m3       = (state_q == IDLE) ? bus.M3dN2 : m3_q;
    m2_max      = sz_m2 - MATRIXSIZE_W'(1);
    m1_max      = sz_m1 - MATRIXSIZE_W'(1);
    m3_max      = sz_m3 - MATRIXSIZE_W'(1);
    j_wrap      = (j_q == m2_max);
    c_wrap      = (c_q == m3_max);
    final_issue = j_wrap && c_wrap && (r_q == m1_max);

    lane_addr_d[0] = '0;
    lane_en_d[0]   = 1'b0;
    lane_last_d[0] = 1'b0;
    for (int k = 1; k < N1; k++) begin
      lane_addr_d[k] = lane_addr_q[k-1];
      lane_en_d[k]   = lane_en_q[k-1];
      lane_last_d[k] = lane_last_q[k-1];
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          m2_d = bus.M2;
          m1_d = bus.M1dN1;
          m3_d = bus.M3dN2;
          if ((bus.M2 == '0) || (bus.M1dN1 == '0) || (bus.M3dN2 == '0)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            issue   = 1'b1;
          end
        end
      end
      RUN: issue = 1'b1;
      DRAIN: begin
        if (drain_q == DRAIN_W'(N1 - 1)) state_d = DONE;
        else                             drain_d = drain_q + DRAIN_W'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      lane_addr_d[0] = base_q + ADDR_W'(j_q);
      lane_en_d[0]   = 1'b1;
      lane_last_d[0] = j_wrap;
      // Row base advances by M2 only when the column-block replay count wraps.
      if (!j_wrap) begin
        j_d = j_q + MATRIXSIZE_W'(1);
      end else begin
        j_d = '0;
        if (!c_wrap) begin
          c_d = c_q + MATRIXSIZE_W'(1);
        end else begin
          c_d    = '0;
          r_d    = r_q + MATRIXSIZE_W'(1);
          base_d = base_q + ADDR_W'(sz_m2);
        end
      end
      // Counters return to zero so the next pass starts from the origin.
      if (final_issue) begin
        state_d = DRAIN;
        drain_d = '0;
        j_d     = '0;
        c_d     = '0;
        r_d     = '0;
        base_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the lane shift registers are reset too, because idle lanes must read back as zero.
    if (rst) begin
      state_q     <= IDLE;
      m2_q        <= '0;
      m1_q        <= '0;
      m3_q        <= '0;
      j_q         <= '0;
      c_q         <= '0;
      r_q         <= '0;
      base_q      <= '0;
      drain_q     <= '0;
      lane_en_q   <= '0;
      lane_last_q <= '0;
      for (int k = 0; k < N1; k++) lane_addr_q[k] <= '0;
    end else if (!bus.stall) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q     <= state_d;
      m2_q        <= m2_d;
      m1_q        <= m1_d;
      m3_q        <= m3_d;
      j_q         <= j_d;
      c_q         <= c_d;
      r_q         <= r_d;
      base_q      <= base_d;
      drain_q     <= drain_d;
      lane_en_q   <= lane_en_d;
      lane_last_q <= lane_last_d;
      for (int k = 0; k < N1; k++) lane_addr_q[k] <= lane_addr_d[k];
    end
  end

  always_comb begin
    bus.rd_addr_A = '0;
    for (int k = 0; k < N1; k++) bus.rd_addr_A[k*ADDR_W +: ADDR_W] = lane_addr_q[k];
  end

  // Enables are gated by stall so a held address is never read twice.
  assign bus.rd_en_A   = lane_en_q & {N1{~bus.stall}};
  assign bus.rd_last_A = lane_last_q;
  assign bus.busy      = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_mem_read_a.sv
// Self-checking bench for mem_read_a: directed scenarios plus randomized passes compared
// against an element-index model of the skewed read stream.
module tb_mem_read_a;

  localparam int N1     = 4;
  localparam int MW     = 16;
  localparam int ADDR_W = 12;
  localparam int MAX_CYC = 20000;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_read_a_if #(.N1(N1), .MATRIXSIZE_W(MW), .ADDR_W(ADDR_W)) bus ();

  mem_read_a #(.N1(N1), .MATRIXSIZE_W(MW), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element e of the pass is A[r*N1+k][j] with j fastest, then c, then r.
  function automatic logic [ADDR_W-1:0] ref_addr(input int e, input int m2, input int m3);
    int j;
    int r;
    j = e % m2;
    r = e / (m2 * m3);
    return ADDR_W'(r * m2 + j);
  endfunction

  // Drives one start and follows the pass cycle by cycle. Model time t counts
  // non-stalled edges since start; lane k shows element t-1-k.
  task automatic run_pass(input string name, input int m2, input int m1, input int m3,
                          input int stall_lo, input int stall_hi, input int stall_pct,
                          input int start_pulse, input bit perturb);
    int L, done_t, t, n, e;
    bit stall_now, valid;
    logic [N1*ADDR_W-1:0] exp_addr;
    logic [N1-1:0]        exp_en, exp_last;
    logic                 exp_busy, exp_done;
    L      = m2 * m1 * m3;
    done_t = (L == 0) ? 1 : L + N1;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.stall = 1'b0;
    bus.M2    = MW'(m2);
    bus.M1dN1 = MW'(m1);
    bus.M3dN2 = MW'(m3);
    @(posedge clk); #1;
    bus.start = 1'b0;
    t = 1;
    n = 1;
    while (t <= done_t + 1 && n < MAX_CYC) begin
      stall_now = (n >= stall_lo && n <= stall_hi) || (int'($urandom_range(99)) < stall_pct);
      bus.stall = stall_now;
      bus.start = (n == start_pulse) || (perturb && t < done_t && $urandom_range(7) == 0);
      if (perturb) begin
        bus.M2    = MW'($urandom_range(6));
        bus.M1dN1 = MW'($urandom_range(6));
        bus.M3dN2 = MW'($urandom_range(6));
      end
      @(negedge clk);
      exp_addr = '0;
      exp_en   = '0;
      exp_last = '0;
      for (int k = 0; k < N1; k++) begin
        e     = t - 1 - k;
        valid = (L > 0) && (e >= 0) && (e < L);
        if (valid) begin
          exp_addr[k*ADDR_W +: ADDR_W] = ref_addr(e, m2, m3);
          exp_en[k]   = !stall_now;
          exp_last[k] = ((e % m2) == m2 - 1);
        end
      end
      exp_busy = (L > 0) && (t < done_t);
      exp_done = (t == done_t);
      checks++;
      if (bus.rd_en_A !== exp_en) begin
        failures++;
        $display("FAIL %s cycle %0d rd_en_A got=%b exp=%b", name, n, bus.rd_en_A, exp_en);
      end
      checks++;
      if (bus.rd_addr_A !== exp_addr) begin
        failures++;
        $display("FAIL %s cycle %0d rd_addr_A got=%h exp=%h", name, n, bus.rd_addr_A, exp_addr);
      end
      checks++;
      if (bus.rd_last_A !== exp_last) begin
        failures++;
        $display("FAIL %s cycle %0d rd_last_A got=%b exp=%b", name, n, bus.rd_last_A, exp_last);
      end
      checks++;
      if (bus.busy !== exp_busy) begin
        failures++;
        $display("FAIL %s cycle %0d busy got=%b exp=%b", name, n, bus.busy, exp_busy);
      end
      checks++;
      if (bus.done !== exp_done) begin
        failures++;
        $display("FAIL %s cycle %0d done got=%b exp=%b", name, n, bus.done, exp_done);
      end
      @(posedge clk); #1;
      if (!stall_now) t++;
      n++;
    end
    checks++;
    if (n >= MAX_CYC) begin
      failures++;
      $display("FAIL %s timeout after %0d cycles, model time %0d of %0d", name, n, t, done_t + 1);
    end
    bus.stall = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.M2    = '0;
    bus.M1dN1 = '0;
    bus.M3dN2 = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.rd_addr_A, bus.rd_en_A, bus.rd_last_A, bus.busy, bus.done} !== '0) begin
        failures++;
        $display("FAIL reset cycle %0d outputs got addr=%h en=%b last=%b busy=%b done=%b exp all 0",
                 i, bus.rd_addr_A, bus.rd_en_A, bus.rd_last_A, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_basic();
    run_pass("t1_basic", 3, 2, 2, 0, -1, 0, -1, 1'b0);
  endtask

  task automatic test_stall_window();
    run_pass("t3_stall", 3, 2, 2, 5, 7, 0, -1, 1'b0);
  endtask

  task automatic test_zero_size();
    run_pass("t4_m3_zero", 3, 2, 0, 0, -1, 0, -1, 1'b0);
    run_pass("t4_m2_zero", 0, 2, 2, 0, -1, 0, -1, 1'b0);
    run_pass("t4_m1_zero", 3, 0, 2, 0, -1, 0, -1, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_pass("t4_restart", 3, 2, 2, 0, -1, 0, 5, 1'b0);
    run_pass("size_change", 3, 2, 2, 0, -1, 0, -1, 1'b1);
  endtask

  task automatic test_single();
    run_pass("t6_single", 1, 1, 1, 0, -1, 0, -1, 1'b0);
  endtask

  task automatic test_abort();
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.stall = 1'b0;
    bus.M2    = MW'(3);
    bus.M1dN1 = MW'(2);
    bus.M3dN2 = MW'(2);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL abort pre-reset busy got=%b exp=1", bus.busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.rd_addr_A, bus.rd_en_A, bus.rd_last_A, bus.busy, bus.done} !== '0) begin
        failures++;
        $display("FAIL abort cycle %0d outputs got addr=%h en=%b last=%b busy=%b done=%b exp all 0",
                 7 + i, bus.rd_addr_A, bus.rd_en_A, bus.rd_last_A, bus.busy, bus.done);
      end
    end
    run_pass("t5_after_abort", 3, 2, 2, 0, -1, 0, -1, 1'b0);
  endtask

  task automatic test_full_range();
    run_pass("addr_full_range", 64, 64, 1, 0, -1, 0, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int p = 0; p < 25; p++) begin
      run_pass($sformatf("random_%0d", p),
               int'($urandom_range(5, 1)), int'($urandom_range(3, 1)), int'($urandom_range(3, 0)),
               0, -1, int'($urandom_range(40)), -1, (p % 2) == 1);
    end
  endtask

  task automatic test_back_to_back();
    run_pass("b2b_a", 2, 1, 3, 0, -1, 0, -1, 1'b0);
    run_pass("b2b_b", 4, 3, 1, 0, -1, 30, -1, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_stall_window();
    test_zero_size();
    test_start_ignored();
    test_single();
    test_abort();
    test_full_range();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
